// File: rtl/fp_alu_top.sv
`default_nettype none
// ============================================================================
//  Module   : fp_alu_top
//  Purpose  : Single-precision floating-point ALU with an internal operand
//             ROM. A loadData rising edge fetches the next {A, B} pair, and a
//             control rising edge captures A op B into the registered
//             outputs. Arithmetic truncates toward zero. Denormal inputs are
//             read as signed zero, and underflow flushes to signed zero.
//  Ports    : clk            system clock
//             reset          asynchronous, active-high clear of all state
//             loadData       level request, acts once per rising edge
//             control        level request, acts once per rising edge
//             select[1:0]    00 add, 01 sub, 10 mul, 11 div
//             out[31:0]      registered IEEE-754 result
//             exception      registered overflow / NaN / infinity flag
//             zeroDiv        registered divide-by-zero flag
//             digit7..digit0 7-segment {g,f,e,d,c,b,a} glyph per out nibble
//  Revision : 1.0  initial release
// ============================================================================
module fp_alu_top #(
   parameter int DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        loadData,
   input  logic        control,
   input  logic [1:0]  select,
   output logic [31:0] out,
   output logic        exception,
   output logic        zeroDiv,
   output logic [6:0]  digit7,
   output logic [6:0]  digit6,
   output logic [6:0]  digit5,
   output logic [6:0]  digit4,
   output logic [6:0]  digit3,
   output logic [6:0]  digit2,
   output logic [6:0]  digit1,
   output logic [6:0]  digit0
);

   localparam int          PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] C_QNAN = 32'h7FC0_0000;
   localparam logic [30:0] C_INF  = 31'h7F80_0000;

   // Operand image: entry = {A, B}
   function automatic logic [63:0] rom_image(input logic [PTR_W-1:0] idx);
      case (int'(idx))
         0:       rom_image = 64'h3FC00000_40100000;
         1:       rom_image = 64'h40A00000_40000000;
         2:       rom_image = 64'h3F800000_00000000;
         3:       rom_image = 64'h00000000_00000000;
         4:       rom_image = 64'h7F000000_7F000000;
         5:       rom_image = 64'h3F800000_33000001;
         6:       rom_image = 64'h3F800000_2F800000;
         7:       rom_image = 64'hC0490FDB_3FB504F3;
         8:       rom_image = 64'h00400000_3F800000;
         9:       rom_image = 64'h3F800000_80400000;
         10:      rom_image = 64'h7F800000_FF800000;
         11:      rom_image = 64'h7FC00000_3F800000;
         12:      rom_image = 64'h7F800000_00000000;
         13:      rom_image = 64'h00800000_3F000000;
         14:      rom_image = 64'h7F7FFFFF_7F7FFFFF;
         15:      rom_image = 64'h80000000_00000000;
         16:      rom_image = 64'h3EAAAAAB_3F2AAAAB;
         17:      rom_image = 64'h40490FDB_C0490FDB;
         18:      rom_image = 64'h3F800000_40400000;
         19:      rom_image = 64'hC2F6E979_44FA0000;
         20:      rom_image = 64'h3F800001_3F7FFFFF;
         21:      rom_image = 64'h4B800000_3F800000;
         22:      rom_image = 64'h0DA24260_72C0F000;
         23:      rom_image = 64'h5E8A4C3B_21D5F0A3;
         24:      rom_image = 64'h80800000_80800000;
         25:      rom_image = 64'h00FFFFFF_80800001;
         26:      rom_image = 64'h3F800000_7F800000;
         27:      rom_image = 64'hFF800000_3F800000;
         28:      rom_image = 64'h12345678_9ABCDEF0;
         29:      rom_image = 64'h7F000000_3F000000;
         30:      rom_image = 64'h00800000_4B000000;
         31:      rom_image = 64'h41200000_C0A00000;
         default: rom_image = 64'h0;
      endcase
   endfunction

   // Final packing: {exception, result}. Biased exponent >= 255 saturates to
   // signed infinity; <= 0 flushes to signed zero without raising exception.
   function automatic logic [32:0] pack(input logic sign,
                                        input logic signed [10:0] exp,
                                        input logic [23:0] man);
      if (exp >= 11'sd255)
         pack = {1'b1, sign, C_INF};
      else if (exp <= 11'sd0)
         pack = {1'b0, sign, 31'd0};
      else
         pack = {1'b0, sign, exp[7:0], man[22:0]};
   endfunction

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // ---------------------------------------------------------------- state
   logic             r_load_s, r_load_d, r_ctrl_s, r_ctrl_d;
   logic [31:0]      r_a, r_b;
   logic [PTR_W-1:0] r_ptr;

   // Edge pulses come from the registered copies, so an execute lands two
   // clocks after control rises: one to sample, one to capture.
   logic w_load_pulse, w_exec_pulse;
   assign w_load_pulse = r_load_s & ~r_load_d;
   assign w_exec_pulse = r_ctrl_s & ~r_ctrl_d;

   logic [31:0] w_res;
   logic        w_exc, w_zdiv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_s  <= 1'b0;
         r_load_d  <= 1'b0;
         r_ctrl_s  <= 1'b0;
         r_ctrl_d  <= 1'b0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_ptr     <= '0;
         out       <= 32'd0;
         exception <= 1'b0;
         zeroDiv   <= 1'b0;
      end else begin
         r_load_s <= loadData;
         r_load_d <= r_load_s;
         r_ctrl_s <= control;
         r_ctrl_d <= r_ctrl_s;
         // Execute reads the current r_a/r_b, so a coincident load does not
         // affect the captured result.
         if (w_exec_pulse) begin
            out       <= w_res;
            exception <= w_exc;
            zeroDiv   <= w_zdiv;
         end
         if (w_load_pulse) begin
            {r_a, r_b} <= rom_image(r_ptr);
            r_ptr      <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
         end
      end
   end

   // --------------------------------------------------------------- decode
   logic       w_sa, w_sb_eff, w_sb;
   logic [7:0] w_ea, w_eb;
   logic [23:0] w_ma, w_mb;
   logic w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

   assign w_sa     = r_a[31];
   assign w_sb     = r_b[31];
   assign w_sb_eff = r_b[31] ^ (select == 2'b01);
   assign w_ea     = r_a[30:23];
   assign w_eb     = r_b[30:23];
   assign w_a_zero = (w_ea == 8'd0);
   assign w_b_zero = (w_eb == 8'd0);
   assign w_a_nan  = (w_ea == 8'hFF) &&  (|r_a[22:0]);
   assign w_b_nan  = (w_eb == 8'hFF) &&  (|r_b[22:0]);
   assign w_a_inf  = (w_ea == 8'hFF) && !(|r_a[22:0]);
   assign w_b_inf  = (w_eb == 8'hFF) && !(|r_b[22:0]);
   // Denormals carry no hidden bit and are read as zero.
   assign w_ma     = w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
   assign w_mb     = w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};

   // ------------------------------------------------------------- add/sub
   logic        w_swap, w_big_s, w_sml_s;
   logic [7:0]  w_big_e, w_sml_e, w_diff;
   logic [23:0] w_big_m, w_sml_m;
   logic [53:0] w_aligned;
   logic [26:0] w_sml_x;
   logic [27:0] w_sum, w_norm;
   logic [4:0]  w_lead;
   logic [32:0] w_add_pk;

   always_comb begin
      w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
      w_big_s = w_swap ? w_sb_eff : w_sa;
      w_sml_s = w_swap ? w_sa : w_sb_eff;
      w_big_e = w_swap ? w_eb : w_ea;
      w_sml_e = w_swap ? w_ea : w_eb;
      w_big_m = w_swap ? w_mb : w_ma;
      w_sml_m = w_swap ? w_ma : w_mb;
      w_diff  = w_big_e - w_sml_e;
      // Three extra low bits (guard, round, sticky); shifted-out bits fold
      // into the sticky LSB so truncation after subtraction stays exact.
      w_aligned = {w_sml_m, 30'd0} >> ((w_diff > 8'd28) ? 6'd28 : w_diff[5:0]);
      w_sml_x   = w_aligned[53:27] | {26'd0, |w_aligned[26:0]};
      if (w_big_s == w_sml_s)
         w_sum = {1'b0, w_big_m, 3'b000} + {1'b0, w_sml_x};
      else
         w_sum = {1'b0, w_big_m, 3'b000} - {1'b0, w_sml_x};
      w_lead = 5'd0;
      for (int i = 0; i < 28; i++)
         if (w_sum[i]) w_lead = i[4:0];
      w_norm   = w_sum << (5'd27 - w_lead);
      w_add_pk = pack(w_big_s, 11'(int'(w_big_e) + int'(w_lead) - 26), w_norm[27:4]);
   end

   // ------------------------------------------------------------- mul/div
   logic [47:0] w_prod;
   logic [49:0] w_quo;
   logic [32:0] w_mul_pk, w_div_pk;

   assign w_prod   = w_ma * w_mb;
   assign w_mul_pk = w_prod[47]
                   ? pack(w_sa ^ w_sb, 11'(int'(w_ea) + int'(w_eb) - 126), w_prod[47:24])
                   : pack(w_sa ^ w_sb, 11'(int'(w_ea) + int'(w_eb) - 127), w_prod[46:23]);
   // Quotient of 24-bit mantissas scaled by 2^26 lands in [2^25, 2^27).
   assign w_quo    = {w_ma, 26'd0} / {26'd0, w_mb};
   assign w_div_pk = w_quo[26]
                   ? pack(w_sa ^ w_sb, 11'(int'(w_ea) - int'(w_eb) + 127), w_quo[26:3])
                   : pack(w_sa ^ w_sb, 11'(int'(w_ea) - int'(w_eb) + 126), w_quo[25:2]);

   logic w_unused_bits;
   assign w_unused_bits = ^{w_norm[3:0], w_prod[22:0], w_quo[49:27], w_quo[1:0]};

   // -------------------------------------------------------- result select
   always_comb begin
      w_zdiv = 1'b0;
      w_exc  = 1'b0;
      w_res  = 32'd0;
      if (select == 2'b11 && w_b_zero) begin
         w_zdiv = 1'b1;
         w_exc  = 1'b1;
         w_res  = (w_a_zero || w_a_nan) ? C_QNAN : {w_sa ^ w_sb, C_INF};
      end else if (w_a_nan || w_b_nan) begin
         w_exc = 1'b1;
         w_res = C_QNAN;
      end else if (w_a_inf || w_b_inf) begin
         w_exc = 1'b1;
         case (select)
            2'b10:   w_res = (w_a_zero || w_b_zero) ? C_QNAN : {w_sa ^ w_sb, C_INF};
            2'b11:   w_res = (w_a_inf && w_b_inf) ? C_QNAN : {w_sa ^ w_sb, C_INF};
            default: w_res = (w_a_inf && w_b_inf && (w_sa != w_sb_eff)) ? C_QNAN
                           : {(w_a_inf ? w_sa : w_sb_eff), C_INF};
         endcase
      end else begin
         case (select)
            2'b10:
               if (w_a_zero || w_b_zero) w_res = {w_sa ^ w_sb, 31'd0};
               else                      {w_exc, w_res} = w_mul_pk;
            2'b11:
               if (w_a_zero) w_res = {w_sa ^ w_sb, 31'd0};
               else          {w_exc, w_res} = w_div_pk;
            default:
               // Exact cancellation (including 0 + 0) yields +0.
               if (w_sum == 28'd0) w_res = 32'd0;
               else                {w_exc, w_res} = w_add_pk;
         endcase
      end
   end

   // ---------------------------------------------------------------- display
   assign digit7 = hex7(out[31:28]);
   assign digit6 = hex7(out[27:24]);
   assign digit5 = hex7(out[23:20]);
   assign digit4 = hex7(out[19:16]);
   assign digit3 = hex7(out[15:12]);
   assign digit2 = hex7(out[11:8]);
   assign digit1 = hex7(out[7:4]);
   assign digit0 = hex7(out[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_alu_top
//  Purpose  : Self-checking bench for fp_alu_top. A transaction-level model
//             tracks the ROM pointer and operands; results are computed with
//             exact wide-integer arithmetic and then truncated.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_alu_top;

   logic        clk = 1'b0;
   logic        reset, loadData, control;
   logic [1:0]  select;
   logic [31:0] out;
   logic        exception, zeroDiv;
   logic [6:0]  digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0;

   fp_alu_top #(.DEPTH(32)) dut (
      .clk(clk), .reset(reset), .loadData(loadData), .control(control),
      .select(select), .out(out), .exception(exception), .zeroDiv(zeroDiv),
      .digit7(digit7), .digit6(digit6), .digit5(digit5), .digit4(digit4),
      .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] rom [32];
   logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model state
   int          m_ptr;
   logic [31:0] m_a, m_b, m_out;
   logic        m_exc, m_zd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: {zeroDiv, exception, out}
   function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sel);
      logic        sa, sb, sr;
      int          ea, eb, base, p, e;
      logic [23:0] ma, mb;
      logic [319:0] va, vb, mag, mant;
      logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
      sa = a[31];
      sb = (sel == 2'd1) ? ~b[31] : b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_nan = (ea == 255) && (a[22:0] != 0);
      b_nan = (eb == 255) && (b[22:0] != 0);
      a_inf = (ea == 255) && (a[22:0] == 0);
      b_inf = (eb == 255) && (b[22:0] == 0);
      ma = a_zero ? 24'd0 : {1'b1, a[22:0]};
      mb = b_zero ? 24'd0 : {1'b1, b[22:0]};
      sr = 1'b0;
      base = 0;
      if (sel == 2'd3 && b_zero)
         return {2'b11, (a_zero || a_nan) ? 32'h7FC00000 : {a[31] ^ b[31], 31'h7F800000}};
      if (a_nan || b_nan)
         return {2'b01, 32'h7FC00000};
      if (a_inf || b_inf) begin
         if (sel == 2'd2)
            return {2'b01, (a_zero || b_zero) ? 32'h7FC00000 : {sa ^ sb, 31'h7F800000}};
         if (sel == 2'd3)
            return {2'b01, (a_inf && b_inf) ? 32'h7FC00000 : {sa ^ sb, 31'h7F800000}};
         if (a_inf && b_inf && sa != sb)
            return {2'b01, 32'h7FC00000};
         return {2'b01, (a_inf ? sa : sb), 31'h7F800000};
      end
      case (sel)
         2'd2: begin
            if (a_zero || b_zero) return {2'b00, sa ^ sb, 31'd0};
            mag  = 320'(ma) * 320'(mb);
            base = ea + eb - 300;
            sr   = sa ^ sb;
         end
         2'd3: begin
            if (a_zero) return {2'b00, sa ^ sb, 31'd0};
            mag  = (320'(ma) << 60) / 320'(mb);
            base = ea - eb - 60;
            sr   = sa ^ sb;
         end
         default: begin
            // Both operands as exact integers scaled by 2^-149.
            va = 320'(ma) << (a_zero ? 0 : ea - 1);
            vb = 320'(mb) << (b_zero ? 0 : eb - 1);
            if (sa == sb)     begin mag = va + vb; sr = sa; end
            else if (va >= vb) begin mag = va - vb; sr = sa; end
            else               begin mag = vb - va; sr = sb; end
            if (mag == 0) return 34'd0;
            base = -149;
         end
      endcase
      p = 0;
      for (int i = 0; i < 320; i++) if (mag[i]) p = i;
      e = p + base + 127;
      if (e >= 255) return {2'b01, sr, 31'h7F800000};
      if (e <= 0)   return {2'b00, sr, 31'd0};
      mant = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
      return {2'b00, sr, 8'(e), mant[22:0]};
   endfunction

   task automatic check_outputs(input string tag);
      logic [55:0] ed;
      ed = '0;
      for (int i = 7; i >= 0; i--) ed = {ed[48:0], glyph[m_out[i*4 +: 4]]};
      check({tag, "_out"},   {32'd0, out},                 {32'd0, m_out});
      check({tag, "_flags"}, {62'd0, zeroDiv, exception}, {62'd0, m_zd, m_exc});
      check({tag, "_digits"},
            {8'd0, digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0},
            {8'd0, ed});
   endtask

   task automatic model_load();
      {m_a, m_b} = rom[m_ptr];
      m_ptr = (m_ptr + 1) % 32;
   endtask

   task automatic model_exec(input logic [1:0] sel);
      logic [33:0] r;
      r = fp_model(m_a, m_b, sel);
      {m_zd, m_exc, m_out} = r;
   endtask

   task automatic do_load(input int hold);
      @(posedge clk); #1 loadData = 1'b1;
      repeat (2 + hold) @(posedge clk);
      #1 loadData = 1'b0;
      model_load();
      repeat (2) @(posedge clk);
      #1 check_outputs("load_keep");
   endtask

   // Checks the value is unchanged one clock after control rises, new after
   // two, and that holding control while select changes captures nothing more.
   task automatic do_exec(input logic [1:0] sel, input int hold, input logic with_load);
      @(posedge clk); #1 control = 1'b1; select = sel;
      if (with_load) loadData = 1'b1;
      @(posedge clk); #1 check_outputs("latency");
      @(posedge clk); #1
      model_exec(sel);
      if (with_load) model_load();
      check_outputs(with_load ? "exec_load" : "exec");
      repeat (hold) begin
         select = 2'($urandom);
         @(posedge clk); #1;
      end
      control = 1'b0; loadData = 1'b0; select = 2'($urandom);
      repeat (2) @(posedge clk);
      #1 check_outputs("hold");
   endtask

   task automatic do_reset_mid();
      do_load(0);
      @(posedge clk); #3 reset = 1'b1;
      #1;
      m_out = '0; m_exc = 1'b0; m_zd = 1'b0; m_a = '0; m_b = '0; m_ptr = 0;
      check_outputs("reset_async");
      @(posedge clk); #2 reset = 1'b0;
   endtask

   initial begin
      rom[0]  = 64'h3FC00000_40100000;  rom[1]  = 64'h40A00000_40000000;
      rom[2]  = 64'h3F800000_00000000;  rom[3]  = 64'h00000000_00000000;
      rom[4]  = 64'h7F000000_7F000000;  rom[5]  = 64'h3F800000_33000001;
      rom[6]  = 64'h3F800000_2F800000;  rom[7]  = 64'hC0490FDB_3FB504F3;
      rom[8]  = 64'h00400000_3F800000;  rom[9]  = 64'h3F800000_80400000;
      rom[10] = 64'h7F800000_FF800000;  rom[11] = 64'h7FC00000_3F800000;
      rom[12] = 64'h7F800000_00000000;  rom[13] = 64'h00800000_3F000000;
      rom[14] = 64'h7F7FFFFF_7F7FFFFF;  rom[15] = 64'h80000000_00000000;
      rom[16] = 64'h3EAAAAAB_3F2AAAAB;  rom[17] = 64'h40490FDB_C0490FDB;
      rom[18] = 64'h3F800000_40400000;  rom[19] = 64'hC2F6E979_44FA0000;
      rom[20] = 64'h3F800001_3F7FFFFF;  rom[21] = 64'h4B800000_3F800000;
      rom[22] = 64'h0DA24260_72C0F000;  rom[23] = 64'h5E8A4C3B_21D5F0A3;
      rom[24] = 64'h80800000_80800000;  rom[25] = 64'h00FFFFFF_80800001;
      rom[26] = 64'h3F800000_7F800000;  rom[27] = 64'hFF800000_3F800000;
      rom[28] = 64'h12345678_9ABCDEF0;  rom[29] = 64'h7F000000_3F000000;
      rom[30] = 64'h00800000_4B000000;  rom[31] = 64'h41200000_C0A00000;

      m_ptr = 0; m_a = '0; m_b = '0; m_out = '0; m_exc = 1'b0; m_zd = 1'b0;
      reset = 1'b1; loadData = 1'b0; control = 1'b0; select = 2'b00;
      repeat (2) @(posedge clk);
      #1 check_outputs("reset");
      reset = 1'b0;

      // Directed: add, sub then mul without reload, divide-by-zero cases,
      // overflow, held control, wrap of the pointer.
      do_load(0); do_exec(2'b00, 0, 1'b0);
      do_load(0); do_exec(2'b01, 0, 1'b0); do_exec(2'b10, 0, 1'b0);
      do_load(0); do_exec(2'b11, 0, 1'b0);
      do_load(0); do_exec(2'b11, 0, 1'b0);
      do_load(0); do_exec(2'b10, 0, 1'b0);
      do_load(4); do_exec(2'b01, 5, 1'b0);
      for (int i = 6; i < 32; i++) do_load(0);
      do_load(0); do_exec(2'b00, 0, 1'b0);
      do_exec(2'b01, 1, 1'b1);
      do_reset_mid();
      do_load(0); do_exec(2'b00, 0, 1'b0);

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         int k;
         k = $urandom_range(0, 39);
         if (k < 16)       do_load($urandom_range(0, 3));
         else if (k < 32)  do_exec(2'($urandom), $urandom_range(0, 3), 1'b0);
         else if (k < 39)  do_exec(2'($urandom), $urandom_range(0, 2), 1'b1);
         else              do_reset_mid();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
